xidoo_core: RTL and testbench

Parametrised successor to the xidoo accumulator microprocessor, with the control FSM, datapath and unified program/data memory in one block. Data and address widths are generic. The memory is loadable from outside while the core is held in reset. It executes the 8-opcode accumulator ISA (LOAD, STORE, ADD, SUB, IN, JZ, JPOS, HALT) and sits at the top of the xidoo design, driving LEDs and Halt directly.

---
 rtl/xidoo_core_if.sv | 14 +
 rtl/xidoo_core.sv | 146 ++++++++++++++
 tb/tb_xidoo_core.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xidoo_core_if.sv
// Program-load bus for xidoo_core: the external loader drives, the core consumes.
// There is no valid/ready handshake. The loader treats Prog_we as a one-cycle write strobe that
// needs no acknowledge, and the core accepts it only while its reset is asserted.
interface xidoo_core_if #(
  parameter int AW = 5,
  parameter int DW = 8
);
  logic          Prog_we;
  logic [AW-1:0] Prog_addr;
  logic [DW-1:0] Prog_data;

  modport master (output Prog_we, output Prog_addr, output Prog_data);
  modport slave  (input  Prog_we, input  Prog_addr, input  Prog_data);
endinterface

// File: rtl/xidoo_core.sv
// xidoo_core: accumulator CPU (FETCH/DECODE/EXEC/INWAIT/HALT) with unified 2^AW x DW memory.
// Define XIDOO_CORE_ENTER_WAIT_EN to make IN wait for the Enter strobe.
module xidoo_core #(
  parameter int DW = 8,
  parameter int AW = 5
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [DW-1:0] SWT,
  input  logic          Enter,
  xidoo_core_if.slave   prog,
  output logic [DW-1:0] LEDs,
  output logic          Halt,
  output logic [2:0]    dbg_state,
  output logic [AW-1:0] dbg_pc,
  output logic [DW-1:0] dbg_ir
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_INWAIT = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_IN    = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] leds_q, leds_d;
  logic          halt_q, halt_d;

  logic [DW-1:0] mem_q [2**AW];

  logic [2:0]    opcode;
  logic [AW-1:0] ir_addr;
  logic [DW-1:0] mem_rd;
  logic          store_we;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  assign opcode  = ir_q[DW-1 -: 3];
  assign ir_addr = ir_q[AW-1:0];
  assign mem_rd  = mem_q[ir_addr];

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    store_we = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_d    = mem_q[pc_q];
        pc_d    = pc_q + 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (opcode == OP_HALT)    state_d = S_HALT;
        else if (opcode == OP_IN) state_d = S_INWAIT;
        else                      state_d = S_EXEC;
      end
      S_EXEC: begin
        case (opcode)
          OP_LOAD:  a_d = mem_rd;
          OP_STORE: store_we = 1'b1;
          OP_ADD:   a_d = a_q + mem_rd;
          OP_SUB:   a_d = a_q - mem_rd;
          OP_JZ:    if (a_q == '0) pc_d = ir_addr;
          OP_JPOS:  if (!a_q[DW-1] && (a_q != '0)) pc_d = ir_addr;
          default:  a_d = a_q;
        endcase
        state_d = S_FETCH;
      end
      S_INWAIT: begin
`ifdef XIDOO_CORE_ENTER_WAIT_EN
        if (Enter) begin
          a_d     = SWT;
          state_d = S_FETCH;
        end
`else
        a_d     = SWT;
        state_d = S_FETCH;
`endif
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    // Halt and LEDs are registered copies of the next state and accumulator.
    halt_d = (state_d == S_HALT);
    leds_d = a_d;
  end

  // The loader owns the write port during reset. An aborted STORE can never reach it.
  always_comb begin
    if (!RST) begin
      mem_we    = prog.Prog_we;
      mem_waddr = prog.Prog_addr;
      mem_wdata = prog.Prog_data;
    end else begin
      mem_we    = store_we;
      mem_waddr = ir_addr;
      mem_wdata = a_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      leds_q  <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      leds_q  <= leds_d;
      halt_q  <= halt_d;
    end
  end

  assign LEDs      = leds_q;
  assign Halt      = halt_q;
  assign dbg_state = state_q;
  assign dbg_pc    = pc_q;
  assign dbg_ir    = ir_q;

endmodule

// File: tb/tb_xidoo_core.sv
// Bench for xidoo_core: directed programs plus random programs checked against an instruction-level model.
// Follows XIDOO_CORE_ENTER_WAIT_EN the same way the design does.
module tb_xidoo_core;

  logic       CLK;
  logic       RST, RST3;
  logic [7:0] SWT, SWT3;
  logic       Enter, Enter3;
  logic [7:0] LEDs, LEDs3;
  logic       Halt, Halt3;
  logic [2:0] dbg_state, dbg_state3;
  logic [4:0] dbg_pc;
  logic [2:0] dbg_pc3;
  logic [7:0] dbg_ir, dbg_ir3;

  xidoo_core_if #(.AW(5), .DW(8)) pif ();
  xidoo_core_if #(.AW(3), .DW(8)) pif3 ();

  xidoo_core #(.DW(8), .AW(5)) dut (
    .CLK(CLK), .RST(RST), .SWT(SWT), .Enter(Enter), .prog(pif.slave),
    .LEDs(LEDs), .Halt(Halt), .dbg_state(dbg_state), .dbg_pc(dbg_pc), .dbg_ir(dbg_ir)
  );

  xidoo_core #(.DW(8), .AW(3)) dut3 (
    .CLK(CLK), .RST(RST3), .SWT(SWT3), .Enter(Enter3), .prog(pif3.slave),
    .LEDs(LEDs3), .Halt(Halt3), .dbg_state(dbg_state3), .dbg_pc(dbg_pc3), .dbg_ir(dbg_ir3)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int halt_cyc;

  // instruction-level reference model
  int ref_mem [32];
  int ref_a;
  int ref_pc;
  bit ref_halt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    pif.Prog_we = 1'b0;
    tick();
    tick();
    ref_a = 0;
    ref_pc = 0;
    ref_halt = 0;
  endtask

  task automatic release_rst();
    RST = 1'b1;
    cyc = 0;
  endtask

  task automatic load_word(input int addr, input int data);
    pif.Prog_we   = 1'b1;
    pif.Prog_addr = addr[4:0];
    pif.Prog_data = data[7:0];
    tick();
    pif.Prog_we   = 1'b0;
    ref_mem[addr] = data & 255;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 32; i++) load_word(i, $urandom_range(0, 255));
  endtask

  task automatic check_mem_all(input string tag);
    for (int i = 0; i < 32; i++) check_eq(tag, {24'd0, dut.mem_q[i]}, ref_mem[i]);
  endtask

  // Executes one instruction on the DUT and in the model, then compares architectural state.
  task automatic run_instr(input int swt, input int waits);
    int w, op, ad;
    w  = ref_mem[ref_pc];
    op = w >> 5;
    ad = w & 31;
    Enter = 1'b0;
    SWT = 8'($urandom_range(0, 255));
    tick();
    ref_pc = (ref_pc + 1) % 32;
    check_eq("fetch_pc", {27'd0, dbg_pc}, ref_pc);
    check_eq("fetch_ir", {24'd0, dbg_ir}, w);
    tick();
    if (op == 7) begin
      check_eq("halt_on", {31'd0, Halt}, 1);
      ref_halt = 1;
      halt_cyc = cyc;
      tick();
      tick();
      check_eq("halt_hold", {31'd0, Halt}, 1);
      check_eq("halt_pc", {27'd0, dbg_pc}, ref_pc);
      check_eq("halt_leds", {24'd0, LEDs}, ref_a);
      return;
    end
    check_eq("no_halt", {31'd0, Halt}, 0);
    if (op == 4) begin
`ifdef XIDOO_CORE_ENTER_WAIT_EN
      for (int k = 0; k < waits; k++) begin
        tick();
        check_eq("in_hold", {24'd0, LEDs}, ref_a);
      end
      SWT = swt[7:0];
      Enter = 1'b1;
      tick();
      Enter = 1'b0;
`else
      SWT = swt[7:0];
      tick();
`endif
      ref_a = swt & 255;
    end else begin
      tick();
      case (op)
        0: ref_a = ref_mem[ad];
        1: ref_mem[ad] = ref_a;
        2: ref_a = (ref_a + ref_mem[ad]) % 256;
        3: ref_a = (ref_a - ref_mem[ad] + 256) % 256;
        5: if (ref_a == 0) ref_pc = ad;
        6: if (ref_a > 0 && ref_a < 128) ref_pc = ad;
        default: ;
      endcase
      if (op == 1) check_eq("store_mem", {24'd0, dut.mem_q[ad]}, ref_mem[ad]);
    end
    check_eq("leds", {24'd0, LEDs}, ref_a);
    check_eq("pc", {27'd0, dbg_pc}, ref_pc);
  endtask

  initial begin
    RST = 1'b0; SWT = '0; Enter = 1'b0;
    pif.Prog_we = 1'b0; pif.Prog_addr = '0; pif.Prog_data = '0;
    RST3 = 1'b0; SWT3 = '0; Enter3 = 1'b0;
    pif3.Prog_we = 1'b0; pif3.Prog_addr = '0; pif3.Prog_data = '0;

    // reset values
    do_reset();
    check_eq("rst_leds", {24'd0, LEDs}, 0);
    check_eq("rst_halt", {31'd0, Halt}, 0);
    check_eq("rst_pc", {27'd0, dbg_pc}, 0);
    check_eq("rst_ir", {24'd0, dbg_ir}, 0);

    // IN, ADD 30, STORE 31, HALT with 5 at address 30
    fill_random();
    load_word(0, 8'h80); load_word(1, 8'h5E); load_word(2, 8'h3F);
    load_word(3, 8'hE0); load_word(30, 5);
    release_rst();
    run_instr(3, 0);
    run_instr(0, 0);
    run_instr(0, 0);
    check_eq("tp_pre_halt", {31'd0, Halt}, 0);
    run_instr(0, 0);
    check_eq("tp_halt_cycle", halt_cyc, 11);
    check_eq("tp_leds", {24'd0, LEDs}, 8);
    check_eq("tp_mem31", {24'd0, dut.mem_q[31]}, 8);

    // modulo arithmetic: LOAD 20, ADD 21, SUB 22, HALT
    do_reset();
    fill_random();
    load_word(0, 8'h14); load_word(1, 8'h55); load_word(2, 8'h76); load_word(3, 8'hE0);
    load_word(20, 8'hF0); load_word(21, 8'h20); load_word(22, 8'h11);
    release_rst();
    run_instr(0, 0);
    check_eq("wrap_load", {24'd0, LEDs}, 8'hF0);
    run_instr(0, 0);
    check_eq("wrap_add", {24'd0, LEDs}, 8'h10);
    run_instr(0, 0);
    check_eq("wrap_sub", {24'd0, LEDs}, 8'hFF);
    run_instr(0, 0);

    // branches: JPOS on 0x80 falls through, JZ on 0 and JPOS on 1 are taken
    do_reset();
    fill_random();
    load_word(0, 8'h14); load_word(1, 8'hCA); load_word(2, 8'h15); load_word(3, 8'hA8);
    load_word(8, 8'h16); load_word(9, 8'hCF); load_word(15, 8'hE0);
    load_word(20, 8'h80); load_word(21, 8'h00); load_word(22, 8'h01);
    release_rst();
    run_instr(0, 0);
    run_instr(0, 0);
    check_eq("jpos_neg_pc", {27'd0, dbg_pc}, 2);
    run_instr(0, 0);
    run_instr(0, 0);
    check_eq("jz_taken_pc", {27'd0, dbg_pc}, 8);
    check_eq("jz_cycles", cyc, 12);
    run_instr(0, 0);
    run_instr(0, 0);
    check_eq("jpos_pos_pc", {27'd0, dbg_pc}, 15);
    run_instr(0, 0);

    // IN with Enter held low, accumulator preloaded with 0x33
    do_reset();
    fill_random();
    load_word(0, 8'h14); load_word(1, 8'h80); load_word(2, 8'hE0); load_word(20, 8'h33);
    release_rst();
    run_instr(0, 0);
    run_instr(8'h5A, 10);
    check_eq("enter_leds", {24'd0, LEDs}, 8'h5A);
`ifdef XIDOO_CORE_ENTER_WAIT_EN
    check_eq("enter_cycles", cyc, 16);
`else
    check_eq("enter_cycles", cyc, 6);
`endif
    run_instr(0, 0);

    // reset during EXEC of STORE 25, then a load attempt with RST high
    do_reset();
    fill_random();
    load_word(0, 8'h14); load_word(1, 8'h39); load_word(2, 8'hE0);
    load_word(20, 8'h77); load_word(25, 8'h11);
    release_rst();
    run_instr(0, 0);
    tick();
    tick();
    RST = 1'b0;
    tick();
    ref_a = 0; ref_pc = 0;
    check_eq("abort_mem", {24'd0, dut.mem_q[25]}, 8'h11);
    check_eq("abort_leds", {24'd0, LEDs}, 0);
    check_eq("abort_halt", {31'd0, Halt}, 0);
    check_eq("abort_pc", {27'd0, dbg_pc}, 0);
    check_eq("abort_ir", {24'd0, dbg_ir}, 0);
    RST = 1'b1;
    pif.Prog_we = 1'b1; pif.Prog_addr = 5'd25; pif.Prog_data = 8'hAA;
    tick();
    pif.Prog_we = 1'b0;
    check_eq("we_ignored", {24'd0, dut.mem_q[25]}, 8'h11);
    check_eq("restart_pc", {27'd0, dbg_pc}, 1);
    check_eq("restart_ir", {24'd0, dbg_ir}, 8'h14);

    // random programs, self-modifying code included
    for (int r = 0; r < 8; r++) begin
      do_reset();
      fill_random();
      release_rst();
      for (int n = 0; n < 30 && !ref_halt; n++)
        run_instr($urandom_range(0, 255), $urandom_range(0, 3));
      check_mem_all("rand_mem");
    end

    // PC wrap on the AW=3 core: JZ 7, LOAD 6 at address 7, next fetch comes from address 0
    pif3.Prog_we = 1'b1;
    pif3.Prog_addr = 3'd0; pif3.Prog_data = 8'hA7; tick();
    pif3.Prog_addr = 3'd1; pif3.Prog_data = 8'hE0; tick();
    pif3.Prog_addr = 3'd6; pif3.Prog_data = 8'h42; tick();
    pif3.Prog_addr = 3'd7; pif3.Prog_data = 8'h06; tick();
    pif3.Prog_we = 1'b0;
    RST3 = 1'b1;
    tick(); tick(); tick();
    check_eq("w3_jz_pc", {29'd0, dbg_pc3}, 7);
    tick(); tick(); tick();
    check_eq("w3_wrap_pc", {29'd0, dbg_pc3}, 0);
    check_eq("w3_leds", {24'd0, LEDs3}, 8'h42);
    tick();
    check_eq("w3_fetch_ir", {24'd0, dbg_ir3}, 8'hA7);
    check_eq("w3_fetch_pc", {29'd0, dbg_pc3}, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
